// File: rtl/trigger_scan_sequencer.sv
// Per-frame offset scanner and trigger confirmation for the FFT trigger detector.
// Optional TRIG_SEQ_STATS_EN adds fire_count / drop_count statistics outputs.
module trigger_scan_sequencer #(
   parameter int NUM_OFFSETS    = 4,
   parameter int READ_LATENCY   = 2,
   parameter int CONFIRM_FRAMES = 3,
   parameter int HOLDOFF_CYCLES = 1000,
   parameter int HOLDOFF_WIDTH  = 16
) (
   input  logic        clk,
   input  logic        reset_b,
   input  logic        arm,
   input  logic        frame_ready,
   input  logic        bin_hit,
   output logic [1:0]  offset_sel,
   output logic        scan_busy,
   output logic [3:0]  hit_mask,
   output logic [3:0]  confirm_cnt,
   output logic        trigger_event,
`ifdef TRIG_SEQ_STATS_EN
   output logic        frame_dropped,
   output logic [15:0] fire_count,
   output logic [15:0] drop_count
`else
   output logic        frame_dropped
`endif
);

   localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);
   localparam logic [1:0]       OFF_LAST = 2'(NUM_OFFSETS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SCAN, S_EVAL, S_FIRE, S_HOLDOFF
   } state_t;

   state_t                   r_state;
   state_t                   w_next_state;
   logic [1:0]               r_offset_sel, w_offset_sel;
   logic [LAT_W-1:0]         r_lat, w_lat;
   logic [3:0]               r_work_mask, w_work_mask;
   logic [3:0]               r_hit_mask, w_hit_mask;
   logic [3:0]               r_confirm_cnt, w_confirm_cnt;
   logic [HOLDOFF_WIDTH-1:0] r_holdoff, w_holdoff;
   logic                     r_trigger, w_trigger;
   logic                     r_dropped, w_dropped;
   logic                     r_scan_busy, w_scan_busy;
   logic                     w_last_lat;
   logic                     w_frame_hit;
   logic [3:0]               w_cnt_inc;

   assign w_last_lat  = (r_lat == LAT_LAST);
   assign w_frame_hit = |r_work_mask;
   assign w_cnt_inc   = (r_confirm_cnt == 4'hF) ? 4'hF : r_confirm_cnt + 4'd1;

   // State and all registered outputs
   always_ff @(posedge clk or posedge reset_b) begin
      if (reset_b) begin
         r_state       <= S_IDLE;
         r_offset_sel  <= 2'd0;
         r_lat         <= '0;
         r_work_mask   <= 4'd0;
         r_hit_mask    <= 4'd0;
         r_confirm_cnt <= 4'd0;
         r_holdoff     <= '0;
         r_trigger     <= 1'b0;
         r_dropped     <= 1'b0;
         r_scan_busy   <= 1'b0;
      end else begin
         r_state       <= w_next_state;
         r_offset_sel  <= w_offset_sel;
         r_lat         <= w_lat;
         r_work_mask   <= w_work_mask;
         r_hit_mask    <= w_hit_mask;
         r_confirm_cnt <= w_confirm_cnt;
         r_holdoff     <= w_holdoff;
         r_trigger     <= w_trigger;
         r_dropped     <= w_dropped;
         r_scan_busy   <= w_scan_busy;
      end
   end

   // Disarm overrides every transition, including EVAL -> FIRE
   always_comb begin
      w_next_state = r_state;
      if (!arm) begin
         w_next_state = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:    if (frame_ready) w_next_state = S_SCAN;
            S_SCAN:    if (w_last_lat && (r_offset_sel == OFF_LAST)) w_next_state = S_EVAL;
            S_EVAL: begin
               if (w_frame_hit && (w_cnt_inc >= 4'(CONFIRM_FRAMES))) w_next_state = S_FIRE;
               else                                                 w_next_state = S_IDLE;
            end
            S_FIRE:    w_next_state = S_HOLDOFF;
            S_HOLDOFF: if (r_holdoff <= HOLDOFF_WIDTH'(1)) w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_offset_sel  = r_offset_sel;
      w_lat         = r_lat;
      w_work_mask   = r_work_mask;
      w_hit_mask    = r_hit_mask;
      w_confirm_cnt = r_confirm_cnt;
      w_holdoff     = r_holdoff;
      w_trigger     = 1'b0;
      w_dropped     = frame_ready && (r_state != S_IDLE);
      w_scan_busy   = (w_next_state == S_SCAN) || (w_next_state == S_EVAL) ||
                      (w_next_state == S_FIRE);
      case (r_state)
         S_IDLE: begin
            if (w_next_state == S_SCAN) begin
               w_offset_sel = 2'd0;
               w_lat        = '0;
               w_work_mask  = 4'd0;
            end
         end
         S_SCAN: begin
            if (w_last_lat) begin
               w_work_mask[r_offset_sel] = bin_hit;
               if (r_offset_sel != OFF_LAST) begin
                  w_offset_sel = r_offset_sel + 2'd1;
                  w_lat        = '0;
               end
            end else begin
               w_lat = r_lat + LAT_W'(1);
            end
         end
         S_EVAL: begin
            w_hit_mask    = r_work_mask;
            w_confirm_cnt = w_frame_hit ? w_cnt_inc : 4'd0;
         end
         S_FIRE: begin
            w_trigger     = 1'b1;
            w_confirm_cnt = 4'd0;
            w_holdoff     = HOLDOFF_WIDTH'(HOLDOFF_CYCLES);
         end
         S_HOLDOFF: begin
            if (r_holdoff != '0) w_holdoff = r_holdoff - HOLDOFF_WIDTH'(1);
         end
         default: ;
      endcase
      if (w_next_state == S_IDLE) w_offset_sel = 2'd0;
      // Disarm: abandon the frame, keep the last published mask
      if (!arm) begin
         w_confirm_cnt = 4'd0;
         w_trigger     = 1'b0;
         w_hit_mask    = r_hit_mask;
         w_holdoff     = '0;
      end
   end

   assign offset_sel    = r_offset_sel;
   assign scan_busy     = r_scan_busy;
   assign hit_mask      = r_hit_mask;
   assign confirm_cnt   = r_confirm_cnt;
   assign trigger_event = r_trigger;
   assign frame_dropped = r_dropped;

`ifdef TRIG_SEQ_STATS_EN
   logic [15:0] r_fire_count;
   logic [15:0] r_drop_count;

   // Counters wrap naturally at 0xFFFF
   always_ff @(posedge clk or posedge reset_b) begin
      if (reset_b) begin
         r_fire_count <= 16'd0;
         r_drop_count <= 16'd0;
      end else begin
         if (w_trigger) r_fire_count <= r_fire_count + 16'd1;
         if (w_dropped) r_drop_count <= r_drop_count + 16'd1;
      end
   end

   assign fire_count = r_fire_count;
   assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_trigger_scan_sequencer.sv
// Directed bench for trigger_scan_sequencer at default parameters
// (NUM_OFFSETS=4, READ_LATENCY=2, CONFIRM_FRAMES=3, HOLDOFF_CYCLES=1000).
module tb_trigger_scan_sequencer;

   logic       clk = 1'b0;
   logic       reset_b;
   logic       arm;
   logic       frame_ready;
   logic       bin_hit;
   logic [3:0] hit_en;
   logic [1:0] offset_sel;
   logic       scan_busy;
   logic [3:0] hit_mask;
   logic [3:0] confirm_cnt;
   logic       trigger_event;
   logic       frame_dropped;
`ifdef TRIG_SEQ_STATS_EN
   logic [15:0] fire_count;
   logic [15:0] drop_count;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int n_trig  = 0;

   always #5 clk = ~clk;

   // Detector model: hit only on the offsets enabled for the current frame
   assign bin_hit = hit_en[offset_sel];

   trigger_scan_sequencer dut (
      .clk           (clk),
      .reset_b       (reset_b),
      .arm           (arm),
      .frame_ready   (frame_ready),
      .bin_hit       (bin_hit),
      .offset_sel    (offset_sel),
      .scan_busy     (scan_busy),
      .hit_mask      (hit_mask),
      .confirm_cnt   (confirm_cnt),
      .trigger_event (trigger_event),
`ifdef TRIG_SEQ_STATS_EN
      .frame_dropped (frame_dropped),
      .fire_count    (fire_count),
      .drop_count    (drop_count)
`else
      .frame_dropped (frame_dropped)
`endif
   );

   always @(posedge clk) if (trigger_event === 1'b1) n_trig++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic pulse_frame();
      frame_ready = 1'b1;
      tick();
      frame_ready = 1'b0;
   endtask

   // Full frame: returns 9 cycles after the sampling edge, with EVAL results visible
   task automatic run_frame(input logic [3:0] hits, input logic [3:0] exp_mask,
                            input logic [3:0] exp_cnt);
      hit_en = hits;
      pulse_frame();
      check("scan_busy_start", {31'd0, scan_busy}, 32'd1);
      check("offset_start", {30'd0, offset_sel}, 32'd0);
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i == 2) check("offset_step1", {30'd0, offset_sel}, 32'd1);
         if (i == 7) check("offset_step3", {30'd0, offset_sel}, 32'd3);
      end
      tick();
      check("hit_mask", {28'd0, hit_mask}, {28'd0, exp_mask});
      check("confirm_cnt", {28'd0, confirm_cnt}, {28'd0, exp_cnt});
      check("no_early_trig", {31'd0, trigger_event}, 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_offset"}, {30'd0, offset_sel}, 32'd0);
      check({tag, "_busy"}, {31'd0, scan_busy}, 32'd0);
      check({tag, "_mask"}, {28'd0, hit_mask}, 32'd0);
      check({tag, "_cnt"}, {28'd0, confirm_cnt}, 32'd0);
      check({tag, "_trig"}, {31'd0, trigger_event}, 32'd0);
      check({tag, "_drop"}, {31'd0, frame_dropped}, 32'd0);
   endtask

   initial begin
      reset_b     = 1'b1;
      arm         = 1'b0;
      frame_ready = 1'b0;
      hit_en      = 4'd0;
      ticks(2);
      check_reset_outputs("reset");
      reset_b = 1'b0;
      tick();

      // Three hit frames 200 cycles apart confirm a trigger 11 cycles after the third
      arm = 1'b1;
      run_frame(4'b0100, 4'b0100, 4'd1);
      ticks(190);
      run_frame(4'b0100, 4'b0100, 4'd2);
      ticks(190);
      run_frame(4'b0100, 4'b0100, 4'd3);
      tick();
      check("trigger_fire", {31'd0, trigger_event}, 32'd1);
      check("cnt_after_fire", {28'd0, confirm_cnt}, 32'd0);
      check("busy_holdoff", {31'd0, scan_busy}, 32'd0);
      tick();
      check("trigger_one_cycle", {31'd0, trigger_event}, 32'd0);

      // Frames inside hold-off are dropped; one after it scans normally
      ticks(98);
      pulse_frame();
      check("drop_holdoff_100", {31'd0, frame_dropped}, 32'd1);
      check("no_scan_holdoff", {31'd0, scan_busy}, 32'd0);
      tick();
      check("drop_pulse_end", {31'd0, frame_dropped}, 32'd0);
      ticks(798);
      pulse_frame();
      check("drop_holdoff_900", {31'd0, frame_dropped}, 32'd1);
      ticks(109);
      run_frame(4'b0100, 4'b0100, 4'd1);
      check("trig_count_1", n_trig, 32'd1);

      // Disarmed frame in IDLE is ignored silently; disarm clears the count
      arm = 1'b0;
      pulse_frame();
      check("disarm_cnt_clear", {28'd0, confirm_cnt}, 32'd0);
      check("disarm_no_drop", {31'd0, frame_dropped}, 32'd0);
      check("disarm_no_scan", {31'd0, scan_busy}, 32'd0);
      arm = 1'b1;
      tick();

      // hit, hit, miss, hit
      run_frame(4'b0100, 4'b0100, 4'd1);
      tick();
      run_frame(4'b0100, 4'b0100, 4'd2);
      tick();
      run_frame(4'b0000, 4'b0000, 4'd0);
      tick();
      run_frame(4'b0001, 4'b0001, 4'd1);
      tick();
      check("pattern_no_trig", n_trig, 32'd1);

      // Frame arriving 5 cycles into a scan is flagged and does not disturb it
      hit_en = 4'b1000;
      pulse_frame();
      ticks(4);
      pulse_frame();
      check("drop_in_scan", {31'd0, frame_dropped}, 32'd1);
      check("scan_continues", {31'd0, scan_busy}, 32'd1);
      ticks(4);
      check("mid_scan_mask", {28'd0, hit_mask}, 32'h8);
      check("mid_scan_cnt", {28'd0, confirm_cnt}, 32'd2);
      tick();

      // Disarm in the 2nd-to-last SCAN cycle of what would be the confirming frame
      hit_en = 4'b0010;
      pulse_frame();
      ticks(6);
      arm = 1'b0;
      tick();
      check("abort_busy", {31'd0, scan_busy}, 32'd0);
      check("abort_cnt", {28'd0, confirm_cnt}, 32'd0);
      check("abort_offset", {30'd0, offset_sel}, 32'd0);
      check("abort_mask_kept", {28'd0, hit_mask}, 32'h8);
      arm = 1'b1;
      ticks(5);
      check("abort_no_trig", n_trig, 32'd1);

      // Fire again, then reset during hold-off
      run_frame(4'b0010, 4'b0010, 4'd1);
      run_frame(4'b0010, 4'b0010, 4'd2);
      run_frame(4'b0010, 4'b0010, 4'd3);
      tick();
      check("second_fire", {31'd0, trigger_event}, 32'd1);
`ifdef TRIG_SEQ_STATS_EN
      check("fire_count", {16'd0, fire_count}, 32'd2);
      check("drop_count", {16'd0, drop_count}, 32'd3);
`endif
      ticks(50);
      reset_b = 1'b1;
      #2;
      check_reset_outputs("midhold_reset");
`ifdef TRIG_SEQ_STATS_EN
      check("fire_count_rst", {16'd0, fire_count}, 32'd0);
      check("drop_count_rst", {16'd0, drop_count}, 32'd0);
`endif
      @(posedge clk);
      #1;
      reset_b = 1'b0;
      tick();
      run_frame(4'b0010, 4'b0010, 4'd1);
      check("trig_count_final", n_trig, 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
